// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared encodings for pipeline control blocks
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [1:0] SEL_A_VALA = 2'b00;
    localparam logic [1:0] SEL_A_VALC = 2'b01;
    localparam logic [1:0] SEL_A_DEC  = 2'b10;
    localparam logic [1:0] SEL_A_INC  = 2'b11;

    localparam logic SEL_B_VALB = 1'b0;
    localparam logic SEL_B_ZERO = 1'b1;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } exe_state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - jXX/cmovXX condition evaluation from {ZF,SF,OF}
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf, sf, of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf ^ of) | zf;
            C_L:     cnd = sf ^ of;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !(sf ^ of);
            C_G:     cnd = !(sf ^ of) && !zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_ctrl.sv
// rtl/exe_ctrl.sv - Y86-64 execute-stage controller: E slot, ALU controls, CC, halt
module exe_ctrl
    import y86_pkg::*;
#(
    parameter int STACK_STEP = 8,
    parameter int STAT_W     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [STAT_W-1:0] in_stat,
    input  logic              alu_zf,
    input  logic              alu_sf,
    input  logic              alu_of,
    input  logic              m_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        alu_ctrl,
    output logic [1:0]        alu_sel_a,
    output logic              alu_sel_b,
    output logic              set_cc,
    output logic [2:0]        cc,
    output logic              cnd,
    output logic              halted
);

    // The ALU realises -STACK_STEP/+STACK_STEP from the sel_a code alone.
    if (STACK_STEP <= 0 || (STACK_STEP % 8) != 0) begin : g_bad_step
        $error("STACK_STEP must be a positive multiple of 8");
    end

    exe_state_t        state, state_nxt;
    logic              e_full;
    logic [3:0]        e_icode;
    logic [3:0]        e_ifun;
    logic [STAT_W-1:0] e_stat;
    logic              fire_in, fire_out;
    logic              cnd_raw;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready  = !e_full || out_ready;
                out_valid = e_full;
                // The faulting instruction itself still leaves E before the core stops.
                if (e_full && out_ready && (e_stat != '0)) state_nxt = ST_HALT;
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid && out_ready;
    assign set_cc   = fire_out && (e_icode == IOPQ) && (e_stat == '0) && !m_exc && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            e_full  <= 1'b0;
            e_icode <= IHALT;
            e_ifun  <= 4'd0;
            e_stat  <= '0;
        end else if (fire_in) begin
            e_full  <= 1'b1;
            e_icode <= in_icode;
            e_ifun  <= in_ifun;
            e_stat  <= in_stat;
        end else if (fire_out) begin
            e_full  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)       cc <= 3'b100;
        else if (set_cc) cc <= {alu_zf, alu_sf, alu_of};
    end

    always_comb begin
        alu_ctrl  = ALU_ADD;
        alu_sel_a = SEL_A_VALA;
        alu_sel_b = SEL_B_ZERO;
        if (e_full) begin
            case (e_icode)
                IRRMOVQ: begin
                    alu_sel_a = SEL_A_VALA;
                    alu_sel_b = SEL_B_ZERO;
                end
                IIRMOVQ: begin
                    alu_sel_a = SEL_A_VALC;
                    alu_sel_b = SEL_B_ZERO;
                end
                IRMMOVQ, IMRMOVQ: begin
                    alu_sel_a = SEL_A_VALC;
                    alu_sel_b = SEL_B_VALB;
                end
                IOPQ: begin
                    alu_ctrl  = (e_ifun > 4'd3) ? ALU_XOR : e_ifun[1:0];
                    alu_sel_a = SEL_A_VALA;
                    alu_sel_b = SEL_B_VALB;
                end
                ICALL, IPUSHQ: begin
                    alu_sel_a = SEL_A_DEC;
                    alu_sel_b = SEL_B_VALB;
                end
                IRET, IPOPQ: begin
                    alu_sel_a = SEL_A_INC;
                    alu_sel_b = SEL_B_VALB;
                end
                default: begin
                    alu_ctrl  = ALU_ADD;
                    alu_sel_a = SEL_A_VALA;
                    alu_sel_b = SEL_B_ZERO;
                end
            endcase
        end
    end

    cond_eval u_cond_eval (
        .cc   (cc),
        .ifun (e_ifun),
        .cnd  (cnd_raw)
    );

    assign cnd = e_full && ((e_icode == IRRMOVQ) || (e_icode == IJXX)) && cnd_raw;

endmodule

// File: tb/tb_exe_ctrl.sv
// tb/tb_exe_ctrl.sv - directed scoreboard bench for exe_ctrl
module tb_exe_ctrl;
    import y86_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_icode;
    logic [3:0] in_ifun;
    logic [1:0] in_stat;
    logic       alu_zf, alu_sf, alu_of;
    logic       m_exc;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] alu_ctrl;
    logic [1:0] alu_sel_a;
    logic       alu_sel_b;
    logic       set_cc;
    logic [2:0] cc;
    logic       cnd;
    logic       halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ctrl;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       cnd;
        logic       scc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clock = ~clock;

    exe_ctrl #(.STACK_STEP(8), .STAT_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_icode  (in_icode),
        .in_ifun   (in_ifun),
        .in_stat   (in_stat),
        .alu_zf    (alu_zf),
        .alu_sf    (alu_sf),
        .alu_of    (alu_of),
        .m_exc     (m_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .alu_sel_a (alu_sel_a),
        .alu_sel_b (alu_sel_b),
        .set_cc    (set_cc),
        .cc        (cc),
        .cnd       (cnd),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] icode, input logic [3:0] ifun, input logic [1:0] stat,
                         input logic [1:0] e_ctrl, input logic [1:0] e_sa, input logic e_sb,
                         input logic e_cnd, input logic e_scc);
        exp_t e;
        in_valid = 1'b1;
        in_icode = icode;
        in_ifun  = ifun;
        in_stat  = stat;
        #1;
        chk("issue_in_ready", {3'b0, in_ready}, 4'h1);
        e.ctrl = e_ctrl; e.sel_a = e_sa; e.sel_b = e_sb; e.cnd = e_cnd; e.scc = e_scc;
        sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic zf, input logic sf, input logic of, input logic mexc);
        exp_t e;
        alu_zf = zf; alu_sf = sf; alu_of = of;
        m_exc = mexc;
        out_ready = 1'b1;
        #1;
        chk("drain_out_valid", {3'b0, out_valid}, 4'h1);
        chk("drain_in_ready", {3'b0, in_ready}, 4'h1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("alu_ctrl", {2'b0, alu_ctrl}, {2'b0, e.ctrl});
            chk("alu_sel_a", {2'b0, alu_sel_a}, {2'b0, e.sel_a});
            chk("alu_sel_b", {3'b0, alu_sel_b}, {3'b0, e.sel_b});
            chk("cnd", {3'b0, cnd}, {3'b0, e.cnd});
            chk("set_cc", {3'b0, set_cc}, {3'b0, e.scc});
        end
        tick();
        out_ready = 1'b0;
        m_exc = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_icode = 4'h0; in_ifun = 4'h0; in_stat = STAT_AOK;
        alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0; m_exc = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_cc", {1'b0, cc}, 4'h4);
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_halted", {3'b0, halted}, 4'h0);
        chk("rst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("rst_set_cc", {3'b0, set_cc}, 4'h0);
        chk("rst_cnd", {3'b0, cnd}, 4'h0);
        chk("rst_ctrl", {2'b0, alu_ctrl}, 4'h0);
        chk("rst_sel_a", {2'b0, alu_sel_a}, 4'h0);
        chk("rst_sel_b", {3'b0, alu_sel_b}, 4'h1);

        issue(IOPQ, 4'd1, STAT_AOK, ALU_SUB, SEL_A_VALA, SEL_B_VALB, 1'b0, 1'b1);
        drain(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cc_after_subq", {1'b0, cc}, 4'h2);

        issue(IJXX, C_L, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b1, 1'b0);
        drain(1'b1, 1'b1, 1'b1, 1'b0);
        issue(IJXX, C_G, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b1, 1'b1, 1'b1, 1'b0);
        issue(IRRMOVQ, C_E, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        chk("cc_after_branches", {1'b0, cc}, 4'h2);

        issue(IPUSHQ, 4'd0, STAT_AOK, ALU_ADD, SEL_A_DEC, SEL_B_VALB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b1;
            #1;
            chk("stall_out_valid", {3'b0, out_valid}, 4'h1);
            chk("stall_in_ready", {3'b0, in_ready}, 4'h0);
            chk("stall_sel_a", {2'b0, alu_sel_a}, {2'b0, SEL_A_DEC});
            chk("stall_set_cc", {3'b0, set_cc}, 4'h0);
            tick();
            chk("stall_cc", {1'b0, cc}, 4'h2);
        end
        drain(1'b1, 1'b1, 1'b1, 1'b0);
        chk("pushq_gone", {3'b0, out_valid}, 4'h0);

        issue(IOPQ, 4'd0, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_VALB, 1'b0, 1'b0);
        drain(1'b1, 1'b0, 1'b1, 1'b1);
        chk("cc_after_mexc", {1'b0, cc}, 4'h2);

        issue(IOPQ, 4'd3, STAT_AOK, ALU_XOR, SEL_A_VALA, SEL_B_VALB, 1'b0, 1'b1);
        drain(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cc_after_xorq", {1'b0, cc}, 4'h4);
        issue(IJXX, C_E, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b1, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IJXX, C_NE, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IJXX, C_YES, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b1, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IJXX, 4'd7, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IJXX, C_LE, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b1, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);

        issue(IOPQ, 4'd2, STAT_AOK, ALU_AND, SEL_A_VALA, SEL_B_VALB, 1'b0, 1'b1);
        drain(1'b0, 1'b0, 1'b1, 1'b0);
        chk("cc_after_andq", {1'b0, cc}, 4'h1);
        issue(IJXX, C_GE, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);

        issue(IIRMOVQ, 4'd0, STAT_AOK, ALU_ADD, SEL_A_VALC, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IMRMOVQ, 4'd0, STAT_AOK, ALU_ADD, SEL_A_VALC, SEL_B_VALB, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IPOPQ, 4'd0, STAT_AOK, ALU_ADD, SEL_A_INC, SEL_B_VALB, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(ICALL, 4'd0, STAT_AOK, ALU_ADD, SEL_A_DEC, SEL_B_VALB, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IRET, 4'd0, STAT_AOK, ALU_ADD, SEL_A_INC, SEL_B_VALB, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(INOP, 4'd0, STAT_AOK, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        issue(IOPQ, 4'd5, STAT_AOK, ALU_XOR, SEL_A_VALA, SEL_B_VALB, 1'b0, 1'b1);
        drain(1'b0, 1'b0, 1'b1, 1'b0);
        chk("cc_after_badop", {1'b0, cc}, 4'h1);

        issue(IHALT, 4'd0, STAT_HLT, ALU_ADD, SEL_A_VALA, SEL_B_ZERO, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_halted", {3'b0, halted}, 4'h1);
        chk("halt_in_ready", {3'b0, in_ready}, 4'h0);
        chk("halt_out_valid", {3'b0, out_valid}, 4'h0);

        in_valid = 1'b1; in_icode = IOPQ; in_ifun = 4'd0; in_stat = STAT_AOK;
        out_ready = 1'b1; alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halted_in_ready", {3'b0, in_ready}, 4'h0);
            chk("halted_out_valid", {3'b0, out_valid}, 4'h0);
            chk("halted_set_cc", {3'b0, set_cc}, 4'h0);
            chk("halted_sticky", {3'b0, halted}, 4'h1);
            tick();
            chk("halted_cc", {1'b0, cc}, 4'h1);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rerst_halted", {3'b0, halted}, 4'h0);
        chk("rerst_cc", {1'b0, cc}, 4'h4);
        chk("rerst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("rerst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("scoreboard_drained", sb_q.size() == 0 ? 4'h1 : 4'h0, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_ctrl.md
Name: exe_ctrl

Overview:
- Execute-stage controller for the pipelined Y86-64 core. It sits between the decode→execute pipeline register and the shared 64-bit ALU.
- Holds the in-flight E-stage instruction (icode/ifun/stat) and drives ALU operand-select and op controls.
- Owns the condition-code register (ZF/SF/OF) and produces `cnd` for jXX/cmovXX.
- Runs a valid/ready handshake toward decode and memory, and a halt state machine on non-AOK status.

Parameters:
- STACK_STEP, 8, byte increment applied to rsp by call/push (−) and ret/pop (+).
- STAT_W, 2, status width (0 AOK, 1 HLT, 2 ADR, 3 INS).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  E slot can accept this cycle
- in_icode  in  4  instruction code
- in_ifun  in  4  function code
- in_stat  in  STAT_W  status from fetch/decode
- alu_zf, alu_sf, alu_of  in  1 each  ALU result flags for the current E instruction
- m_exc  in  1  memory or writeback stage holds a non-AOK instruction
- out_valid  out  1  E instruction ready for memory stage
- out_ready  in  1  memory stage accepts
- alu_ctrl  out  2  00 add, 01 sub, 10 and, 11 xor
- alu_sel_a  out  2  00 val_a, 01 val_c, 10 −STACK_STEP, 11 +STACK_STEP
- alu_sel_b  out  1  0 val_b, 1 zero
- set_cc  out  1  CC update strobe for this cycle
- cc  out  3  {ZF,SF,OF}
- cnd  out  1  condition result for E instruction
- halted  out  1  core halted

Behaviour:
Reset:
- e_full=0, CC=3'b100 (ZF=1, SF=0, OF=0), state RUN.
- Resulting outputs: out_valid=0, set_cc=0, cnd=0, halted=0, alu_ctrl=00, alu_sel_a=00, alu_sel_b=1.
- Reset asserted mid-operation discards the E instruction and does not update CC.

FSM states RUN, HALT:
- RUN→HALT when the E instruction carries stat≠AOK and out_valid&out_ready occurs; the instruction itself is delivered.
- HALT is sticky until reset. In HALT: in_ready=0, out_valid=0, set_cc=0, halted=1.

Handshake:
- in_ready = RUN & (!e_full | out_ready).
- Capture on in_valid&in_ready. out_valid = e_full & RUN.
- Accept and drain in the same cycle is legal (back-to-back throughput 1/cycle).
- Stall: out_valid&!out_ready holds the E register and all outputs stable.
- Latency: an instruction captured at edge N is presented from cycle N+1 and leaves at earliest edge N+1.

Operand decode (combinational from the E register; idle when !e_full: add, sel_a 00, sel_b 1):
- 0 halt, 1 nop: add, sel_a 00, sel_b 1.
- 2 rrmovq/cmovXX: add, val_a + 0.
- 3 irmovq: add, val_c + 0.
- 4 rmmovq, 5 mrmovq: add, val_c + val_b.
- 6 OPq: alu_ctrl = ifun[1:0], val_a op val_b; ifun>3 drives 11 (upstream already marks it INS).
- 7 jXX: add, sel_b 1 (ALU unused).
- 8 call, 10 pushq: −STACK_STEP + val_b.
- 9 ret, 11 popq: +STACK_STEP + val_b.
- other icodes: idle controls.

CC update:
- set_cc = out_valid & out_ready & icode==6 & stat==AOK & !m_exc & !reset.
- CC loads {alu_zf, alu_sf, alu_of} at that edge; otherwise CC holds.

cnd:
- Computed from the current CC (before any same-cycle update), for icode 2 and 7.
- ifun 0 → 1; 1 le → (SF^OF)|ZF; 2 l → SF^OF; 3 e → ZF; 4 ne → !ZF; 5 ge → !(SF^OF); 6 g → !(SF^OF)&!ZF; ifun>6 → 0.
- cnd=0 for all other icodes.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT…IPOPQ), status codes, ALU op encodings, condition ifun encodings, sel_a encodings.
- One natural sub-module, `cond_eval` (combinational: cc, ifun → cnd), reused by the fetch branch predictor/recovery logic.

Test Plan:
- Reset then idle → cc=100, out_valid=0, halted=0, in_ready=1.
- subq (icode 6, ifun 1), alu flags ZF=0 SF=1 OF=0, out_ready=1 → alu_ctrl=01, set_cc=1 on the drain cycle, cc becomes 010 next cycle.
- After the previous case, jl (7/2) → cnd=1; jg (7/6) → cnd=0; cmove (2/3) → cnd=0.
- out_ready=0 for 3 cycles with pushq in E → out_valid=1 held, in_ready=0, alu_sel_a=10 stable, no CC change; release → drains, in_ready=1 the same cycle.
- addq in E with m_exc=1 → set_cc=0, cc unchanged.
- halt (stat=HLT) drains → halted=1 the next cycle, in_ready=0 thereafter; a following in_valid is ignored; reset → RUN, cc=100.
